// File: rtl/platform_nios2_debug_pkg.sv
// rtl/platform_nios2_debug_pkg.sv - shared debug-slave types, IR lanes and default widths
package platform_nios2_debug_pkg;
   localparam int SR_W_DEF = 38;
   localparam int IR_W_DEF = 2;

   localparam int IR_OCIMEM    = 0;
   localparam int IR_TRACEMEM  = 1;
   localparam int IR_BREAK     = 2;
   localparam int IR_TRACECTRL = 3;

   typedef struct packed {
      logic [IR_W_DEF-1:0] ir;
      logic [SR_W_DEF-1:0] data;
   } cmd_t;
endpackage

// File: rtl/platform_nios2_debug_sysclk_cmdq_if.sv
// rtl/platform_nios2_debug_sysclk_cmdq_if.sv - command queue output handshake
interface platform_nios2_debug_sysclk_cmdq_if
   import platform_nios2_debug_pkg::*;
#(
   parameter int SR_W = SR_W_DEF,
   parameter int IR_W = IR_W_DEF
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [IR_W-1:0] cmd_ir;
   logic [SR_W-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_ir, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_ir, input cmd_data, output cmd_ready);
endinterface

// File: rtl/platform_nios2_debug_sync_rise.sv
// rtl/platform_nios2_debug_sync_rise.sv - strobe synchroniser with armed rise detector
module platform_nios2_debug_sync_rise #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic level,
   output logic evt
);
   logic [STAGES-1:0] sync;
   logic [STAGES-1:0] fill;
   logic              armed;

   // fill tracks which sync stages hold real samples, so reset zeros never count as "seen low"
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync  <= '0;
         fill  <= '0;
         armed <= 1'b0;
      end else begin
         sync  <= {sync[STAGES-2:0], level};
         fill  <= {fill[STAGES-2:0], 1'b1};
         armed <= fill[STAGES-1] & ~sync[STAGES-1];
      end
   end

   assign evt = armed & sync[STAGES-1];
endmodule

// File: rtl/platform_nios2_debug_sysclk_cmdq.sv
// rtl/platform_nios2_debug_sysclk_cmdq.sv - sysclk-side JTAG debug capture with command FIFO
module platform_nios2_debug_sysclk_cmdq
   import platform_nios2_debug_pkg::*;
#(
   parameter int SR_W        = SR_W_DEF,
   parameter int IR_W        = IR_W_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int ACTION_BIT  = 34
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [IR_W-1:0]             ir_in,
   input  logic [SR_W-1:0]             sr,
   input  logic                        vs_udr,
   input  logic                        vs_uir,
   output logic [SR_W-1:0]             jdo,
   output logic [IR_W-1:0]             jdo_ir,
   output logic [(2**IR_W)-1:0]        take_action,
   output logic [(2**IR_W)-1:0]        take_no_action,
   output logic                        ir_update,
   output logic [$clog2(FIFO_DEPTH):0] cmd_count,
   output logic                        overflow,
   input  logic                        overflow_clr,
   platform_nios2_debug_sysclk_cmdq_if.master cmd
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = IR_W + SR_W;
   localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

   logic          udr_evt;
   logic          uir_evt;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          pop;
   logic          push;
   logic          drop;

   platform_nios2_debug_sync_rise #(.STAGES(SYNC_STAGES)) u_udr (
      .clk     (clk),
      .reset_n (reset_n),
      .level   (vs_udr),
      .evt     (udr_evt)
   );

   platform_nios2_debug_sync_rise #(.STAGES(SYNC_STAGES)) u_uir (
      .clk     (clk),
      .reset_n (reset_n),
      .level   (vs_uir),
      .evt     (uir_evt)
   );

   // a full queue still accepts a push when the head leaves on the same edge
   assign pop  = (count != '0) && cmd.cmd_ready;
   assign push = udr_evt && ((count != FULL_CNT) || pop);
   assign drop = udr_evt && (count == FULL_CNT) && !pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jdo            <= '0;
         jdo_ir         <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         ir_update      <= 1'b0;
         overflow       <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
      end else begin
         take_action    <= '0;
         take_no_action <= '0;
         ir_update      <= uir_evt;
         if (udr_evt) begin
            jdo                    <= sr;
            jdo_ir                 <= ir_in;
            take_action[ir_in]     <= sr[ACTION_BIT];
            take_no_action[ir_in]  <= ~sr[ACTION_BIT];
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {ir_in, sr};
      end
   end

   assign cmd.cmd_valid = (count != '0);
   assign cmd.cmd_ir    = mem[rd_ptr][EW-1:SR_W];
   assign cmd.cmd_data  = mem[rd_ptr][SR_W-1:0];
   assign cmd_count     = count;
endmodule

// File: doc/platform_nios2_debug_sysclk_cmdq.md
Name: platform_nios2_debug_sysclk_cmdq

Overview:
- System-clock side of the JTAG debug slave, generalised in scan-register width, IR width, synchroniser depth and buffering.
- Synchronises the TCK-domain update-DR and update-IR strobes into clk and latches the shifted register (sr) and instruction (ir_in).
- Decodes per-instruction take_action / take_no_action pulses and queues every captured command in a FIFO with valid/ready handshake, so back-to-back JTAG updates are not lost while the OCI logic is busy.

Parameters:
- SR_W, 38: scan register / jdo width.
- IR_W, 2: instruction width; NUM_CMD = 2**IR_W decode lanes.
- SYNC_STAGES, 2: synchroniser flops per strobe; legal range ≥2.
- FIFO_DEPTH, 4: command queue entries; power of two, ≥2.
- ACTION_BIT, 34: sr bit selecting take_action (1) vs take_no_action (0).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ir_in  in  IR_W  instruction from TCK domain; stable around vs_udr.
- sr  in  SR_W  scan register from TCK domain; stable while vs_udr high.
- vs_udr  in  1  update-DR level, TCK domain.
- vs_uir  in  1  update-IR level, TCK domain.
- jdo  out  SR_W  last captured sr.
- jdo_ir  out  IR_W  ir_in captured with jdo.
- take_action  out  NUM_CMD  one-hot one-cycle pulse, lane = captured ir.
- take_no_action  out  NUM_CMD  one-hot one-cycle pulse, lane = captured ir.
- ir_update  out  1  one-cycle pulse per synchronised update-IR.
- cmd_valid  out  1  queue non-empty.
- cmd_ready  in  1  consumer accepts the head entry.
- cmd_ir  out  IR_W  head entry instruction.
- cmd_data  out  SR_W  head entry data.
- cmd_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky: an update was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset values: all outputs 0; all synchroniser flops 0; FIFO empty; edge detectors disarmed.
- Strobe path: each strobe passes through SYNC_STAGES flops, then a rise detector with an armed bit.
  - The armed bit sets only after the synchronised level is seen low.
  - A strobe held high across reset release therefore produces no event.
- Event timing:
  - Clk edge k is the first to sample vs_udr=1.
  - udr_evt is internal and high during cycle k+SYNC_STAGES.
  - All captures are registered on the next edge. Total latency from first sample to outputs: SYNC_STAGES+1 edges.
- On udr_evt, registered:
  - jdo<=sr, jdo_ir<=ir_in.
  - take_action[ir_in]<=sr[ACTION_BIT]; take_no_action[ir_in]<=~sr[ACTION_BIT].
  - All other lanes 0; pulses last exactly one cycle.
  - Push {ir_in,sr} into the FIFO.
- On uir_evt: ir_update pulses one cycle. jdo, the FIFO and the pulses are unaffected.
- udr_evt and uir_evt in the same cycle: both are processed independently.
- FIFO:
  - cmd_valid = count≠0. Pop when cmd_valid && cmd_ready.
  - A pushed entry is visible on cmd_* the cycle after the push edge; no fall-through in the same cycle.
  - cmd_ir/cmd_data hold the head entry while cmd_valid is high; they are don't-care when empty.
  - Pointers wrap modulo FIFO_DEPTH. cmd_count increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- Full boundary:
  - Full + push + pop in the same cycle: both succeed; count stays FIFO_DEPTH; no overflow.
  - Full + push without pop: entry dropped, overflow<=1. jdo and the pulses still update.
- Empty boundary: cmd_ready while empty has no effect.
- overflow_clr: clears overflow next edge; if a dropped push occurs in the same cycle, set wins.
- Async reset mid-operation:
  - Immediate return to reset values; the queue is flushed; in-flight strobes are lost.
  - After release, no event fires until the strobe is seen low then high.

Decomposition:
- Shared package platform_nios2_debug_pkg:
  - IR lane localparams: IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3.
  - Default SR_W/IR_W.
  - Packed command struct type {ir, data}.
- Sub-module platform_nios2_debug_sync_rise: parametrised synchroniser plus armed rise detector, instantiated twice (udr, uir).
- The FIFO stays inline.

Test Plan:
- Single update: ir_in=2, sr=38'h04_0000_1234 (bit34=1), vs_udr high 4 clk → after 3 edges jdo=38'h04_0000_1234, jdo_ir=2, take_action=4'b0100 for one cycle, cmd_valid=1, cmd_count=1.
- No-action decode: ir_in=0, sr bit34=0 → take_no_action=4'b0001 pulse, take_action stays 0; ir_update pulses once for a separate vs_uir rise.
- Overflow: 5 updates with cmd_ready=0, FIFO_DEPTH=4 → cmd_count=4, overflow=1. Heads popped in order are updates 1-4; update 5 appears in jdo only.
- Full with simultaneous push and pop: queue full, cmd_ready=1 in the udr_evt cycle → count stays 4, overflow stays 0, the new entry is last popped.
- Overflow clear vs set: overflow_clr=1 in the same cycle as a dropped push → overflow stays 1; overflow_clr next cycle alone → 0.
- Reset with vs_udr held high: assert reset_n=0 mid-queue (count=3) → count=0 and all pulses 0 immediately. Release with vs_udr=1 → no event. Drop and raise vs_udr → exactly one capture.
